rx_beamformer: RTL and testbench
================================

# rx_beamformer

Receive-side delay-and-sum beamformer: the counterpart of the transmit path that fires the 64-element array for one scanline point. Per-element focusing delays are loaded into a table. After `initiate`, the block buffers one signed echo sample per element per `sample_valid` in per-element ring buffers. It emits one coherently summed output sample per accepted input sample until `scan_len` outputs have been produced, then pulses `done`.

## Interface
- `NUM_EL`, 64, number of array elements (power of 2)
- `DW_INPUT`, 8, signed sample width per element
- `DELAY_DW`, 6, delay width; ring depth `2**DELAY_DW`, MAXD = `2**DELAY_DW-1`
- `LEN_DW`, 10, scanline length counter width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `delay_we`  in  1  delay table write strobe (honoured in IDLE only)
- `delay_idx`  in  $clog2(NUM_EL)  element index for write
- `delay_val`  in  DELAY_DW  delay in samples for that element
- `initiate`  in  1  start scanline (honoured in IDLE only)
- `scan_len`  in  LEN_DW  number of output samples, latched on `initiate`
- `sample_valid`  in  1  `sample_in` valid this cycle
- `sample_in`  in  NUM_EL*DW_INPUT  lane e = bits [e*DW_INPUT +: DW_INPUT], two's complement
- `sum_valid`  out  1  `sum_out` valid
- `sum_out`  out  DW_INPUT+$clog2(NUM_EL)  signed aligned sum
- `busy`  out  1  high in FILL/SUM
- `done`  out  1  one-cycle pulse at scanline end

## Operation
- States: IDLE, FILL, SUM.
- IDLE:
  - `delay_we` writes `delay_val` into `delay[delay_idx]`.
  - `initiate` latches `scan_len`, clears write pointer, sample count m and output count, then goes to FILL.
  - `sample_valid` is ignored.
- FILL/SUM: on `sample_valid`, sample m of each lane is written at `wr_ptr`; `wr_ptr` wraps mod `2**DELAY_DW`; m increments.
- Once m ≥ MAXD (state SUM), each accepted sample m produces output n = m−MAXD:
  - y[n] = Σ_e x_e[n + delay[e]].
  - Tap read offset behind the current write is MAXD−delay[e].
  - Offset 0 (delay = MAXD) bypasses to the current `sample_in` lane.
- FILL→SUM when sample MAXD is accepted, so the first output comes from sample index MAXD.
- SUM→IDLE when output `scan_len` is issued; `done` pulses with that final `sum_valid`.
- `scan_len`=0: straight to IDLE with a `done` pulse on the cycle after `initiate`; no outputs.
- `delay_we` and `initiate` while busy: ignored; the delay table is stable for the whole scanline.
- Arithmetic: sign-extended full-precision sum; the width is exact for NUM_EL lanes, so no saturation or overflow is possible.

## Timing
- Reset values: `sum_valid`=0, `sum_out`=0, `busy`=0, `done`=0, state IDLE, all pointers/counters 0, all delay table entries 0.
- Pipeline latency: `sum_valid` asserts exactly 2 cycles after the clock edge that accepts the producing sample.
  - Stage 1 registers the taps; stage 2 registers the sum.
  - `sum_out` holds its value between valids.
- `busy` rises the cycle after `initiate` is accepted.
- `busy` falls in the same cycle as the `done` pulse.
- Gaps in `sample_valid` stall progress; no output is lost or duplicated.
- `rst` mid-scanline aborts immediately:
  - In-flight pipeline contents are discarded.
  - No `done` is issued.
  - The delay table is cleared.

## Configuration
- `RX_ELEMENT_MASK_EN` defined:
  - Adds input `el_mask` [NUM_EL-1:0], latched on `initiate`.
  - Lanes with mask bit 0 contribute 0 to the sum.
- Undefined: port absent; all lanes always contribute.

## Test plan
- All delays 0, every lane `sample_in` = m for sample m, `scan_len`=4, 67 samples fed back-to-back -> `sum_out` 0, 64, 128, 192 on consecutive cycles; `done` with the 4th.
- Only lane 5 nonzero (value 10 at m=20), `delay[5]`=3, others 0, `scan_len`=30 -> `sum_out`=10 only at n=17, 0 elsewhere.
- All lanes −128 constant, all delays 63 (bypass path), `scan_len`=2 -> `sum_out` = −8192 twice.
- Same stimulus as test 1 with `sample_valid` toggling every other cycle -> identical output sequence, each output 2 cycles after its sample.
- `initiate` and `delay_we` asserted while busy; then `rst` asserted at output 2 -> table unchanged until reset; all outputs 0 after reset; no `done`; a fresh `initiate` works.
- With `RX_ELEMENT_MASK_EN`, `el_mask` = 0x0000_0000_0000_FFFF, test 1 stimulus -> `sum_out` 0, 16, 32, 48.

Source files
------------

// File: rtl/rx_beamformer.sv
// Receive delay-and-sum beamformer: per-element ring buffers, delay-table taps, two-stage summing pipeline.
// Optional per-element masking is enabled with `define RX_ELEMENT_MASK_EN.
module rx_beamformer #(
  parameter int NUM_EL   = 64,
  parameter int DW_INPUT = 8,
  parameter int DELAY_DW = 6,
  parameter int LEN_DW   = 10
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       delay_we,
  input  logic [$clog2(NUM_EL)-1:0]                  delay_idx,
  input  logic [DELAY_DW-1:0]                        delay_val,
  input  logic                                       initiate,
  input  logic [LEN_DW-1:0]                          scan_len,
  input  logic                                       sample_valid,
  input  logic [NUM_EL*DW_INPUT-1:0]                 sample_in,
`ifdef RX_ELEMENT_MASK_EN
  input  logic [NUM_EL-1:0]                          el_mask,
`endif
  output logic                                       sum_valid,
  output logic signed [DW_INPUT+$clog2(NUM_EL)-1:0]  sum_out,
  output logic                                       busy,
  output logic                                       done
);

  localparam int DEPTH = 2**DELAY_DW;
  localparam logic [DELAY_DW-1:0] MAXD = DELAY_DW'(DEPTH - 1);
  localparam int SW = DW_INPUT + $clog2(NUM_EL);

  typedef enum logic [1:0] {IDLE, FILL, SUM} state_t;
  state_t state, state_nxt;

  logic [DELAY_DW-1:0]        delay_tab [NUM_EL];
  logic signed [DW_INPUT-1:0] ring [NUM_EL][DEPTH];
  logic [DELAY_DW-1:0]        wr_ptr, fill_cnt;
  logic [LEN_DW-1:0]          len_q, gen_cnt;
  logic [NUM_EL-1:0]          mask_q;

  logic start, accept, produce, last;
  logic vld_p0, last_p0, vld_p1, last_p1;
  logic [DELAY_DW-1:0]        ptr_p0;
  logic [NUM_EL*DW_INPUT-1:0] sample_p0;
  logic [DELAY_DW-1:0]        off_w [NUM_EL];
  logic [DELAY_DW-1:0]        rd_w [NUM_EL];
  logic signed [DW_INPUT-1:0] tap_nxt [NUM_EL];
  logic signed [DW_INPUT-1:0] tap_p1 [NUM_EL];
  logic signed [SW-1:0]       sum_nxt;

  assign start   = (state == IDLE) && initiate;
  // Once all outputs are generated, further samples are refused while the pipeline drains.
  assign accept  = sample_valid && (state != IDLE) && (gen_cnt != len_q);
  assign produce = accept && ((state == SUM) || (fill_cnt == MAXD));
  assign last    = produce && (gen_cnt == len_q - LEN_DW'(1));
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (initiate && scan_len != '0) state_nxt = FILL;
      FILL: if (accept && fill_cnt == MAXD) state_nxt = SUM;
      SUM:  if (last_p1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < NUM_EL; e++) delay_tab[e] <= '0;
    end else if (state == IDLE && delay_we) begin
      delay_tab[delay_idx] <= delay_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      gen_cnt   <= '0;
      len_q     <= '0;
      mask_q    <= '1;
      vld_p0    <= 1'b0;
      last_p0   <= 1'b0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      sum_valid <= 1'b0;
      sum_out   <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        wr_ptr   <= '0;
        fill_cnt <= '0;
        gen_cnt  <= '0;
        len_q    <= scan_len;
`ifdef RX_ELEMENT_MASK_EN
        mask_q   <= el_mask;
`else
        mask_q   <= '1;
`endif
      end else if (accept) begin
        wr_ptr <= wr_ptr + DELAY_DW'(1);
        if (state == FILL) fill_cnt <= fill_cnt + DELAY_DW'(1);
        if (produce) gen_cnt <= gen_cnt + LEN_DW'(1);
      end
      // stage 0 -> 1
      vld_p0  <= produce;
      last_p0 <= last;
      vld_p1  <= vld_p0;
      last_p1 <= vld_p0 && last_p0;
      // stage 1 -> 2
      sum_valid <= vld_p1;
      if (vld_p1) sum_out <= sum_nxt;
      done <= last_p1 || (start && scan_len == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int e = 0; e < NUM_EL; e++) ring[e][wr_ptr] <= sample_in[e*DW_INPUT +: DW_INPUT];
      ptr_p0    <= wr_ptr;
      sample_p0 <= sample_in;
    end
    if (vld_p0) begin
      for (int e = 0; e < NUM_EL; e++) tap_p1[e] <= tap_nxt[e];
    end
  end

  // Offset zero is the sample written in the producing cycle, taken from the captured input lane.
  always_comb begin
    for (int e = 0; e < NUM_EL; e++) begin
      off_w[e]   = MAXD - delay_tab[e];
      rd_w[e]    = ptr_p0 - off_w[e];
      tap_nxt[e] = (off_w[e] == '0) ? sample_p0[e*DW_INPUT +: DW_INPUT] : ring[e][rd_w[e]];
      if (!mask_q[e]) tap_nxt[e] = '0;
    end
  end

  always_comb begin
    sum_nxt = '0;
    for (int e = 0; e < NUM_EL; e++) sum_nxt = sum_nxt + SW'(tap_p1[e]);
  end

endmodule

// File: tb/tb_rx_beamformer.sv
// Directed bench for rx_beamformer: hand-computed outputs, latency, busy/done timing, reset abort.
module tb_rx_beamformer;
  localparam int NE = 64;
  localparam int DW = 8;
  localparam int LD = 10;
  localparam int SW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, delay_we, initiate, sample_valid;
  logic [5:0] delay_idx, delay_val;
  logic [LD-1:0] scan_len;
  logic [NE*DW-1:0] sample_in;
  logic sum_valid, busy, done;
  logic signed [SW-1:0] sum_out;
`ifdef RX_ELEMENT_MASK_EN
  logic [NE-1:0] el_mask;
`endif

  rx_beamformer dut (
    .clk(clk), .rst(rst), .delay_we(delay_we), .delay_idx(delay_idx), .delay_val(delay_val),
    .initiate(initiate), .scan_len(scan_len), .sample_valid(sample_valid), .sample_in(sample_in),
`ifdef RX_ELEMENT_MASK_EN
    .el_mask(el_mask),
`endif
    .sum_valid(sum_valid), .sum_out(sum_out), .busy(busy), .done(done)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit obs_v [4096];
  bit obs_d [4096];
  bit obs_b [4096];
  longint obs_s [4096];
  int acc_edge [128];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    obs_v[cyc] = sum_valid;
    obs_s[cyc] = sum_out;
    obs_d[cyc] = done;
    obs_b[cyc] = busy;
  endtask

  task automatic chk(input string tag, input longint o, input longint e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic drive(input int mode, input int m);
    for (int e = 0; e < NE; e++) begin
      case (mode)
        0: sample_in[e*DW +: DW] = 8'(m);
        1: sample_in[e*DW +: DW] = (e == 5 && m == 20) ? 8'd10 : 8'd0;
        default: sample_in[e*DW +: DW] = 8'h80;
      endcase
    end
  endtask

  task automatic feed(input int mode, input int n, input bit toggle);
    for (int m = 0; m < n; m++) begin
      drive(mode, m);
      sample_valid = 1'b1;
      acc_edge[m] = cyc + 1;
      step();
      if (toggle) begin
        sample_valid = 1'b0;
        step();
      end
    end
    sample_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic start(input int len);
    initiate = 1'b1;
    scan_len = LD'(len);
    step();
    initiate = 1'b0;
  endtask

  task automatic wr_all(input int v);
    for (int e = 0; e < NE; e++) begin
      delay_we = 1'b1;
      delay_idx = 6'(e);
      delay_val = 6'(v);
      step();
    end
    delay_we = 1'b0;
  endtask

  function automatic int count_v(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) if (obs_v[i]) c++;
    return c;
  endfunction

  function automatic int count_d(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) if (obs_d[i]) c++;
    return c;
  endfunction

  task automatic chk_outs(input string tag, input int nout, input longint base, input longint inc,
                          input bit last_done);
    for (int n = 0; n < nout; n++) begin
      int k = acc_edge[63 + n] + 2;
      chk($sformatf("%s_vld%0d", tag, n), obs_v[k], 1);
      chk($sformatf("%s_sum%0d", tag, n), obs_s[k], base + inc * n);
      chk($sformatf("%s_done%0d", tag, n), obs_d[k], (last_done && n == nout - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int c;
    int k;
    rst = 1'b1; delay_we = 1'b0; initiate = 1'b0; sample_valid = 1'b0;
    delay_idx = '0; delay_val = '0; scan_len = '0; sample_in = '0;
`ifdef RX_ELEMENT_MASK_EN
    el_mask = '1;
`endif
    step(); step();
    chk("rst_vld", sum_valid, 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    step();

    // all delays 0, ramp input
    c = cyc;
    start(4);
    chk("t1_busy_pre", obs_b[c], 0);
    chk("t1_busy_rise", obs_b[cyc], 1);
    feed(0, 67, 1'b0);
    chk_outs("t1", 4, 0, 64, 1'b1);
    chk("t1_nvld", count_v(c + 1, cyc), 4);
    chk("t1_ndone", count_d(c + 1, cyc), 1);
    chk("t1_busy_last", obs_b[acc_edge[66] + 1], 1);
    chk("t1_busy_fall", obs_b[acc_edge[66] + 2], 0);

    // same with sample_valid every other cycle
    c = cyc;
    start(4);
    feed(0, 67, 1'b1);
    chk_outs("t4", 4, 0, 64, 1'b1);
    chk("t4_gap", obs_v[acc_edge[63] + 1], 0);
    chk("t4_nvld", count_v(c + 1, cyc), 4);

    // single spike on lane 5 with delay 3
    delay_we = 1'b1; delay_idx = 6'd5; delay_val = 6'd3;
    step();
    delay_we = 1'b0;
    c = cyc;
    start(30);
    feed(1, 93, 1'b0);
    for (int n = 0; n < 30; n++) begin
      k = acc_edge[63 + n] + 2;
      chk($sformatf("t2_vld%0d", n), obs_v[k], 1);
      chk($sformatf("t2_sum%0d", n), obs_s[k], (n == 17) ? 10 : 0);
    end
    chk("t2_done", obs_d[acc_edge[92] + 2], 1);
    chk("t2_nvld", count_v(c + 1, cyc), 30);

    // bypass path: all delays 63, constant -128
    wr_all(63);
    start(2);
    feed(2, 65, 1'b0);
    chk_outs("t3", 2, -8192, 0, 1'b1);

    // writes/initiate while busy are ignored; reset aborts mid-scanline
    wr_all(0);
    c = cyc;
    start(10);
    for (int m = 0; m < 68; m++) begin
      drive(0, m);
      sample_valid = 1'b1;
      if (m == 10) begin
        delay_we = 1'b1; delay_idx = 6'd0; delay_val = 6'd7;
        initiate = 1'b1; scan_len = 10'd3;
      end
      acc_edge[m] = cyc + 1;
      step();
      delay_we = 1'b0;
      initiate = 1'b0;
    end
    chk_outs("t5", 3, 0, 64, 1'b0);
    rst = 1'b1;
    sample_valid = 1'b0;
    step();
    chk("t5_rst_vld", sum_valid, 0);
    chk("t5_rst_sum", sum_out, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    rst = 1'b0;
    for (int m = 0; m < 5; m++) begin
      drive(0, m);
      sample_valid = 1'b1;
      step();
    end
    sample_valid = 1'b0;
    step(); step();
    chk("t5_post_nvld", count_v(acc_edge[67] + 3, cyc), 0);
    chk("t5_ndone", count_d(c + 1, cyc), 0);
    chk("t5_post_busy", busy, 0);
    c = cyc;
    start(4);
    feed(0, 67, 1'b0);
    chk_outs("t5_fresh", 4, 0, 64, 1'b1);
    chk("t5_fresh_nvld", count_v(c + 1, cyc), 4);

    // zero-length scanline
    start(0);
    chk("t6_done", obs_d[cyc], 1);
    chk("t6_busy", obs_b[cyc], 0);
    step();
    chk("t6_done_off", obs_d[cyc], 0);
    chk("t6_vld", obs_v[cyc], 0);

`ifdef RX_ELEMENT_MASK_EN
    el_mask = 64'h0000_0000_0000_FFFF;
    start(4);
    el_mask = '1;
    feed(0, 67, 1'b0);
    chk_outs("t7", 4, 0, 16, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
